// File: rtl/obi_mux_2_to_1_if.sv
// OBI address/response bundle shared by the masters and the slave side of the 2:1 mux.
interface obi_mux_2_to_1_if;
   logic        req;
   logic        gnt;
   logic [31:0] addr;
   logic        we;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/obi_mux_2_to_1.sv
// Two OBI masters onto one slave: round-robin address-phase arbitration with a
// stall lock, and an in-order ID FIFO that routes each slave response back.
module obi_mux_2_to_1 #(
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic             clk,
   input  logic             rst,
   obi_mux_2_to_1_if.slave  m0,
   obi_mux_2_to_1_if.slave  m1,
   obi_mux_2_to_1_if.master slv,
   output logic             bad_state
);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   logic [MAX_OUTSTANDING-1:0] fifo_q;
   logic [PW-1:0]              wr_ptr, rd_ptr;
   logic [CW-1:0]              count;
   logic                       lock_q, sel_q, last_q;
   logic                       sel, req_sel, full, empty, slv_req, push, pop, head;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   // A stalled address phase keeps its owner; otherwise the master not served last wins a tie.
   always_comb begin
      sel = 1'b0;
      if (lock_q)                sel = sel_q;
      else if (m0.req && m1.req) sel = ~last_q;
      else if (m1.req)           sel = 1'b1;
   end

   assign req_sel = sel ? m1.req : m0.req;
   assign full    = (count == CW'(MAX_OUTSTANDING));
   assign empty   = (count == '0);
   assign slv_req = req_sel & ~full & ~rst;
   assign push    = slv_req & slv.gnt;
   assign pop     = slv.rvalid & ~empty & ~rst;
   assign head    = fifo_q[rd_ptr];

   assign slv.req   = slv_req;
   assign slv.addr  = sel ? m1.addr  : m0.addr;
   assign slv.we    = sel ? m1.we    : m0.we;
   assign slv.be    = sel ? m1.be    : m0.be;
   assign slv.wdata = sel ? m1.wdata : m0.wdata;

   assign m0.gnt    = push & ~sel;
   assign m1.gnt    = push & sel;
   assign m0.rvalid = pop & ~head;
   assign m1.rvalid = pop & head;
   assign m0.rdata  = slv.rdata;
   assign m1.rdata  = slv.rdata;
   assign bad_state = slv.rvalid & empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         fifo_q <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         lock_q <= 1'b0;
         sel_q  <= 1'b0;
         last_q <= 1'b1;
      end else begin
         if (push) begin
            fifo_q[wr_ptr] <= sel;
            wr_ptr         <= ptr_inc(wr_ptr);
            last_q         <= sel;
            lock_q         <= 1'b0;
         end else if (slv_req) begin
            lock_q <= 1'b1;
            sel_q  <= sel;
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         if (push && !pop)      count <= count + 1'b1;
         else if (!push && pop) count <= count - 1'b1;
      end
   end
endmodule

// File: tb/tb_obi_mux_2_to_1.sv
// Randomized bench for obi_mux_2_to_1: cycle reference model of the arbitration
// rules plus an end-to-end response scoreboard checked by a separate monitor.
module tb_obi_mux_2_to_1;
   localparam int MAXO = 2;

   logic clk = 1'b0;
   logic rst;
   logic bad_state;

   obi_mux_2_to_1_if m0_if ();
   obi_mux_2_to_1_if m1_if ();
   obi_mux_2_to_1_if slv_if ();

   obi_mux_2_to_1 #(.MAX_OUTSTANDING(MAXO)) dut (
      .clk       (clk),
      .rst       (rst),
      .m0        (m0_if),
      .m1        (m1_if),
      .slv       (slv_if),
      .bad_state (bad_state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        id;
      logic [31:0] addr;
   } sq_t;

   int          tests = 0;
   int          fails = 0;
   sq_t         sq[$];
   logic [31:0] expq0[$];
   logic [31:0] expq1[$];

   function automatic logic [31:0] rsp_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Response monitor: every master rvalid must carry the data for that master's oldest grant.
   always @(negedge clk) begin
      if (m0_if.rvalid) begin
         if (expq0.size() == 0) chk("rsp0_unexpected", 32'd1, 32'd0);
         else chk("rsp0_data", m0_if.rdata, expq0.pop_front());
      end
      if (m1_if.rvalid) begin
         if (expq1.size() == 0) chk("rsp1_unexpected", 32'd1, 32'd0);
         else chk("rsp1_data", m1_if.rdata, expq1.pop_front());
      end
   end

   initial begin
      bit          mreq[2];
      bit          gprev[2];
      logic [31:0] maddr[2];
      logic [31:0] mwd[2];
      logic        mwe[2];
      logic [3:0]  mbe[2];
      int          cnt, req_pct, gnt_pct, rv_pct;
      bit          last, stl, sid, sel, ereq, hs, pop, hid, sgnt, srv;
      logic [31:0] srd;

      cnt = 0; last = 1'b1; stl = 1'b0; sid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         mreq[i] = 1'b0; gprev[i] = 1'b0; maddr[i] = '0; mwd[i] = '0; mwe[i] = 1'b0; mbe[i] = '0;
      end
      rst = 1'b1;
      m0_if.req = 1'b0; m0_if.addr = '0; m0_if.we = 1'b0; m0_if.be = '0; m0_if.wdata = '0;
      m1_if.req = 1'b0; m1_if.addr = '0; m1_if.we = 1'b0; m1_if.be = '0; m1_if.wdata = '0;
      slv_if.gnt = 1'b0; slv_if.rvalid = 1'b0; slv_if.rdata = '0;

      for (int c = 0; c < 1520; c++) begin
         @(posedge clk);
         #1;
         rst = (c < 2) || (c == 650) || (c == 651);
         if (c < 300)       begin req_pct = 70; gnt_pct = 100; rv_pct = 90;  end
         else if (c < 600)  begin req_pct = 60; gnt_pct = 60;  rv_pct = 50;  end
         else if (c < 700)  begin req_pct = 90; gnt_pct = 100; rv_pct = 0;   end
         else if (c < 800)  begin req_pct = 90; gnt_pct = 80;  rv_pct = 30;  end
         else if (c < 1500) begin
            req_pct = $urandom_range(100); gnt_pct = $urandom_range(100); rv_pct = $urandom_range(100);
         end else begin req_pct = 0; gnt_pct = 100; rv_pct = 100; end

         // A master keeps its address phase until granted, then may start another.
         for (int i = 0; i < 2; i++) begin
            if (!mreq[i] || gprev[i]) begin
               mreq[i]  = ($urandom_range(99) < req_pct);
               maddr[i] = $urandom;
               mwd[i]   = $urandom;
               mwe[i]   = 1'($urandom_range(1));
               mbe[i]   = 4'($urandom_range(15));
            end
            gprev[i] = 1'b0;
         end
         sgnt = ($urandom_range(99) < gnt_pct);
         if (rst)                srv = 1'b0;
         else if (sq.size() > 0) srv = ($urandom_range(99) < rv_pct);
         else                    srv = (c < 1500) && ($urandom_range(7) == 0);
         srd = (sq.size() > 0) ? rsp_of(sq[0].addr) : $urandom;

         m0_if.req = mreq[0]; m0_if.addr = maddr[0]; m0_if.we = mwe[0]; m0_if.be = mbe[0]; m0_if.wdata = mwd[0];
         m1_if.req = mreq[1]; m1_if.addr = maddr[1]; m1_if.we = mwe[1]; m1_if.be = mbe[1]; m1_if.wdata = mwd[1];
         slv_if.gnt = sgnt; slv_if.rvalid = srv; slv_if.rdata = srd;

         @(negedge clk);
         if (rst) begin
            chk("rst_slv_req", 32'(slv_if.req), 32'd0);
            chk("rst_gnt0",    32'(m0_if.gnt), 32'd0);
            chk("rst_gnt1",    32'(m1_if.gnt), 32'd0);
            chk("rst_rv0",     32'(m0_if.rvalid), 32'd0);
            chk("rst_rv1",     32'(m1_if.rvalid), 32'd0);
            cnt = 0; last = 1'b1; stl = 1'b0;
            sq.delete(); expq0.delete(); expq1.delete();
            continue;
         end

         if (stl)                       sel = sid;
         else if (mreq[0] && mreq[1])   sel = ~last;
         else                           sel = mreq[1];
         ereq = mreq[sel] && (cnt < MAXO);
         hs   = ereq && sgnt;
         chk("slv_req", 32'(slv_if.req), 32'(ereq));
         if (ereq) begin
            chk("slv_addr",  slv_if.addr,  maddr[sel]);
            chk("slv_we",    32'(slv_if.we), 32'(mwe[sel]));
            chk("slv_be",    32'(slv_if.be), 32'(mbe[sel]));
            chk("slv_wdata", slv_if.wdata, mwd[sel]);
         end
         chk("gnt0", 32'(m0_if.gnt), 32'(hs && !sel));
         chk("gnt1", 32'(m1_if.gnt), 32'(hs && sel));
         pop = srv && (sq.size() > 0);
         hid = pop ? sq[0].id : 1'b0;
         chk("rv0", 32'(m0_if.rvalid), 32'(pop && !hid));
         chk("rv1", 32'(m1_if.rvalid), 32'(pop && hid));
         chk("bad_state", 32'(bad_state), 32'(srv && (sq.size() == 0)));

         if (pop) begin
            void'(sq.pop_front());
            cnt--;
         end
         if (hs) begin
            sq.push_back('{id: sel, addr: maddr[sel]});
            if (sel) expq1.push_back(rsp_of(maddr[sel]));
            else     expq0.push_back(rsp_of(maddr[sel]));
            cnt++;
            last = sel;
            stl = 1'b0;
            gprev[sel] = 1'b1;
         end else if (ereq) begin
            stl = 1'b1;
            sid = sel;
         end
      end

      @(negedge clk);
      chk("drain_q0", 32'(expq0.size()), 32'd0);
      chk("drain_q1", 32'(expq1.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
